keypad_scanner: RTL
===================

# keypad_scanner

Parametrised matrix-keypad scanner for the 100 MHz board domain. Drives one column low at a time, samples rows after a settle delay, assembles a full-matrix frame, and runs a press/release debounce state machine over successive frames. Emits a one-cycle `key_valid` strobe with a registered key code, a `key_held` level, a `key_release` strobe and a multi-key (ghosting) flag, for consumption by downstream entry/display logic.

## Interface
- `NCOL`, 4: number of keypad columns (2..8)
- `NROW`, 4: number of keypad rows (2..8)
- `SCAN_TICKS`, 100000: clock cycles each column is driven (1 ms at 100 MHz); must exceed `SETTLE`+2
- `SETTLE`, 10: cycle index within a column slot at which rows are sampled
- `DEBOUNCE_FRAMES`, 4: consecutive identical frames required to accept a press or a release (1..15)
- `HEX_MAP`, 1: 1 = legacy 4x4 hex legend (only legal when `NCOL`=`NROW`=4); 0 = linear code `row*NCOL + col`
- `clk_100MHz`  input  1  system clock
- `rst_n`  input  1  synchronous reset, active-low
- `row`  input  NROW  row sense lines, active-low; bit NROW-1 = row 0
- `col`  output  NCOL  column drive, active-low one-hot; bit NCOL-1 = column 0
- `key_code`  output  CW = max(1, clog2(NROW*NCOL))  code of last accepted key
- `key_valid`  output  1  one-cycle strobe, new press accepted
- `key_held`  output  1  high from accepted press until accepted release
- `key_release`  output  1  one-cycle strobe, release accepted
- `multi_key`  output  1  high while the last evaluated frame contained two or more pressed keys

## Operation
- Scan: `scan_timer` counts 0..SCAN_TICKS-1; on wrap `col_idx` advances, NCOL-1 wraps to 0. `col` registered, reflects `col_idx`.
- Sample: at `scan_timer`==SETTLE, `~row` stored into frame slot `col_idx`. When `col_idx`==NCOL-1 the frame is complete and evaluated the same edge (using the live sample for the last column).
- Frame evaluation: count = pressed bits in frame; single = count==1; idx = position of that bit.
- HEX_MAP=1 legend (row0..3 per column): col0 1,4,7,0; col1 2,5,8,F; col2 3,6,9,E; col3 A,B,C,D. HEX_MAP=0: idx = row*NCOL+col.
- FSM, frame-rate transitions only, debounce counter `cnt`:
  - IDLE: single -> DB_PRESS, cand=idx, cnt=1 (if DEBOUNCE_FRAMES=1 go straight to HELD with accept). Otherwise stay.
  - DB_PRESS: single and idx==cand -> cnt+1; at cnt==DEBOUNCE_FRAMES -> HELD, key_code=cand, key_valid. Different single key -> cand=idx, cnt=1. Zero or multi -> IDLE.
  - HELD: count==0 -> DB_REL, cnt=1 (DEBOUNCE_FRAMES=1: release immediately). Anything else stays; a different key while held is ignored (no new strobe).
  - DB_REL: count==0 -> cnt+1; at DEBOUNCE_FRAMES -> IDLE, key_release. Any key pressed -> HELD, cnt cleared, no strobe.
- `multi_key` updated every frame evaluation; multi frames never accept a press.
- `key_code` changes only on accept; holds through release.

## Timing
- Reset (rst_n low at edge): scan_timer=0, col_idx=0, `col` = column 0 low (4x4: 0111), frame cleared, FSM=IDLE, cnt=0, key_code=0, key_valid=0, key_held=0, key_release=0, multi_key=0. Reset mid-debounce or mid-hold discards state with no strobe.
- Frame period = NCOL*SCAN_TICKS cycles; evaluation edge = sample edge of column NCOL-1.
- key_valid/key_release high exactly one cycle, the cycle after the evaluation edge; key_code and key_held update on that same edge.
- Press latency: DEBOUNCE_FRAMES evaluations from the first frame containing the key (worst case +1 frame for a press arriving after its column's sample).
- First press after reset: earliest accept at evaluation DEBOUNCE_FRAMES.
- Row changes outside the SETTLE cycle are ignored.

## Test plan
- Params NCOL=NROW=4, SCAN_TICKS=20, SETTLE=3, DEBOUNCE_FRAMES=2, HEX_MAP=1; after reset `col` cycles 0111,1011,1101,1110 every 20 cycles -> verify sequence and wrap.
- Hold key 5 (col1,row1) from reset -> key_valid one cycle at second evaluation (cycle 143 after reset release), key_code=4'h5, key_held=1.
- Press 9 for exactly one frame, then release -> no key_valid, FSM back to IDLE, key_code unchanged.
- Hold 3, then release -> key_release one cycle two evaluations after first empty frame, key_held=0, key_code stays 3; bounce (one empty frame then key) keeps key_held high, no strobes.
- Hold A and B together -> multi_key=1, no key_valid; drop B -> A accepted after two frames, multi_key=0.
- HEX_MAP=0, NCOL=3, NROW=2: press row1,col2 -> key_code=5; assert rst_n low mid-debounce -> all outputs at reset values, no strobe.

Source files
------------

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: matrix drive/sense lines plus key event outputs.
// master = scanner, slave = keypad/consumer side.
interface keypad_scanner_if #(
  parameter int NCOL = 4,
  parameter int NROW = 4
);
  localparam int CW =
    (NROW * NCOL > 1) ? $clog2(NROW * NCOL) : 1;

  logic [NROW-1:0] row;
  logic [NCOL-1:0] col;
  logic [CW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;
  logic            key_release;
  logic            multi_key;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held,
    output key_release,
    output multi_key
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held,
    input  key_release,
    input  multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-strobed matrix keypad scanner with
// frame-rate press/release debounce and ghosting flag.
module keypad_scanner #(
  parameter int NCOL            = 4,
  parameter int NROW            = 4,
  parameter int SCAN_TICKS      = 100000,
  parameter int SETTLE          = 10,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int HEX_MAP         = 1
) (
  input  logic        clk_100MHz,
  input  logic        rst_n,
  keypad_scanner_if.master kp
);
  localparam int CW =
    (NROW * NCOL > 1) ? $clog2(NROW * NCOL) : 1;
  localparam int TW = $clog2(SCAN_TICKS);
  localparam int XW = (NCOL > 1) ? $clog2(NCOL) : 1;
  localparam bit USE_HEX =
    (HEX_MAP == 1) && (NCOL == 4) && (NROW == 4);
  localparam logic [3:0] DB4 = 4'(DEBOUNCE_FRAMES);
  // nibble (row*4+col): legacy hex legend
  localparam logic [63:0] HEX_LUT =
    64'hDEF0_C987_B654_A321;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HELD,
    S_DB_REL
  } state_t;

  logic [TW-1:0]             r_timer;
  logic [XW-1:0]             r_col_idx;
  logic [NCOL-1:0]           r_col;
  logic [NCOL-1:0][NROW-1:0] r_frame;
  state_t                    r_state;
  logic [3:0]                r_cnt;
  logic [CW-1:0]             r_cand;
  logic [CW-1:0]             r_code;
  logic                      r_valid;
  logic                      r_held;
  logic                      r_rel;
  logic                      r_multi;

  logic                      w_slot_end;
  logic                      w_sample_en;
  logic                      w_eval;
  logic [XW-1:0]             w_col_next;
  logic [NROW-1:0]           w_sample;
  logic [NCOL-1:0][NROW-1:0] w_frame;
  logic [1:0]                w_pop;
  logic [CW-1:0]             w_idx;
  logic                      w_none;
  logic                      w_single;
  logic                      w_many;
  logic [3:0]                w_cnt_inc;

  function automatic logic [NCOL-1:0] col_drive(
    input logic [XW-1:0] idx
  );
    logic [NCOL-1:0] v;
    v = '1;
    v[NCOL-1-int'(idx)] = 1'b0;
    return v;
  endfunction

  function automatic logic [CW-1:0] key_index(
    input int c,
    input int r
  );
    if (USE_HEX)
      return CW'(HEX_LUT[((r * 4 + c) & 15) * 4 +: 4]);
    else
      return CW'(r * NCOL + c);
  endfunction

  assign w_slot_end  = (r_timer == TW'(SCAN_TICKS - 1));
  assign w_sample_en = (r_timer == TW'(SETTLE));
  assign w_eval      = w_sample_en &&
                       (r_col_idx == XW'(NCOL - 1));
  assign w_col_next  = (r_col_idx == XW'(NCOL - 1)) ?
                       '0 : r_col_idx + 1'b1;
  assign w_none      = (w_pop == 2'd0);
  assign w_single    = (w_pop == 2'd1);
  assign w_many      = (w_pop == 2'd2);
  assign w_cnt_inc   = r_cnt + 4'd1;

  // active-low rows, reordered so index r is keypad row r
  always_comb begin
    w_sample = '0;
    for (int r = 0; r < NROW; r++)
      w_sample[r] = ~kp.row[NROW-1-r];
  end

  // frame as seen at evaluation: last column taken live
  always_comb begin
    w_frame = r_frame;
    w_frame[NCOL-1] = w_sample;
    w_pop = 2'd0;
    w_idx = '0;
    for (int c = 0; c < NCOL; c++) begin
      for (int r = 0; r < NROW; r++) begin
        if (w_frame[c][r]) begin
          if (w_pop != 2'd2)
            w_pop = w_pop + 2'd1;
          w_idx = key_index(c, r);
        end
      end
    end
  end

  // column slot timer and registered column drive
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_col_idx <= '0;
      r_col     <= col_drive('0);
    end else if (w_slot_end) begin
      r_timer   <= '0;
      r_col_idx <= w_col_next;
      r_col     <= col_drive(w_col_next);
    end else begin
      r_timer   <= r_timer + 1'b1;
    end
  end

  // capture settled rows into the current column slot
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n)
      r_frame <= '0;
    else if (w_sample_en)
      r_frame[r_col_idx] <= w_sample;
  end

  // frame-rate press/release debounce with registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
      r_rel   <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_rel   <= 1'b0;
      if (w_eval) begin
        r_multi <= w_many;
        unique case (r_state)
          S_IDLE: begin
            if (w_single) begin
              if (DEBOUNCE_FRAMES == 1) begin
                r_state <= S_HELD;
                r_code  <= w_idx;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_state <= S_DB_PRESS;
                r_cand  <= w_idx;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_DB_PRESS: begin
            if (w_single && (w_idx == r_cand)) begin
              if (w_cnt_inc == DB4) begin
                r_state <= S_HELD;
                r_code  <= r_cand;
                r_valid <= 1'b1;
                r_held  <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt   <= w_cnt_inc;
              end
            end else if (w_single) begin
              r_cand <= w_idx;
              r_cnt  <= 4'd1;
            end else begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          end
          S_HELD: begin
            if (w_none) begin
              if (DEBOUNCE_FRAMES == 1) begin
                r_state <= S_IDLE;
                r_rel   <= 1'b1;
                r_held  <= 1'b0;
                r_cnt   <= '0;
              end else begin
                r_state <= S_DB_REL;
                r_cnt   <= 4'd1;
              end
            end
          end
          S_DB_REL: begin
            if (w_none) begin
              if (w_cnt_inc == DB4) begin
                r_state <= S_IDLE;
                r_rel   <= 1'b1;
                r_held  <= 1'b0;
                r_cnt   <= '0;
              end else begin
                r_cnt   <= w_cnt_inc;
              end
            end else begin
              r_state <= S_HELD;
              r_cnt   <= '0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign kp.col         = r_col;
  assign kp.key_code    = r_code;
  assign kp.key_valid   = r_valid;
  assign kp.key_held    = r_held;
  assign kp.key_release = r_rel;
  assign kp.multi_key   = r_multi;

endmodule
